// File: rtl/demux_pkg.sv
// Shared constants for the round-robin demux dispatcher: FSM state encoding
// and the width of the saturating skip counter.
package demux_pkg;

  localparam logic [0:0] DISP_EMPTY = 1'b0;
  localparam logic [0:0] DISP_HOLD  = 1'b1;

  localparam int SKIP_CNT_W = 8;

endpackage : demux_pkg

// File: rtl/onehot_dec.sv
// Binary index to N-bit one-hot decoder with an enable gate.
// The output is all-zero whenever the enable is low.
module onehot_dec #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N-1:0]     onehot_o
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign onehot_o[gi] = en_i && (idx_i == SEL_W'(gi));
    end
  endgenerate

endmodule : onehot_dec

// File: rtl/demux_rr_dispatch.sv
// One-word round-robin dispatcher: holds a word and offers it to lanes in turn,
// skipping a lane that stays not-ready for MAX_WAIT+1 offered cycles.
module demux_rr_dispatch
  import demux_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_OUT  = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic [NUM_OUT-1:0]         out_valid,
  input  logic [NUM_OUT-1:0]         out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_OUT)-1:0] out_sel,
  output logic [SKIP_CNT_W-1:0]      skip_cnt
);

  localparam int SEL_W  = $clog2(NUM_OUT);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [0:0]            state_q, state_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [SKIP_CNT_W-1:0] skip_q, skip_d;

  logic hold;
  logic out_fire;
  logic in_fire;

  assign hold     = (state_q == DISP_HOLD);
  assign out_fire = hold && out_ready[ptr_q];
  // Deliberately combinational from out_ready so a full stream runs at one word per cycle.
  assign in_ready = !hold || out_fire;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    data_d  = data_q;
    skip_d  = skip_q;

    if (in_fire) begin
      data_d  = in_data;
      state_d = DISP_HOLD;
    end else if (out_fire) begin
      state_d = DISP_EMPTY;
    end

    // Dispatch has priority over a timeout landing in the same cycle.
    if (out_fire) begin
      ptr_d  = ptr_q + SEL_W'(1);
      wait_d = '0;
    end else if (hold) begin
      if (wait_q == WAIT_W'(MAX_WAIT)) begin
        ptr_d  = ptr_q + SEL_W'(1);
        wait_d = '0;
        if (skip_q != {SKIP_CNT_W{1'b1}}) begin
          skip_d = skip_q + SKIP_CNT_W'(1);
        end
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DISP_EMPTY;
      ptr_q   <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      skip_q  <= skip_d;
    end
  end

  onehot_dec #(
    .N     (NUM_OUT),
    .SEL_W (SEL_W)
  ) u_valid_dec (
    .idx_i    (ptr_q),
    .en_i     (hold),
    .onehot_o (out_valid)
  );

  assign out_data = data_q;
  assign out_sel  = ptr_q;
  assign skip_cnt = skip_q;

endmodule : demux_rr_dispatch

// File: tb/tb_demux_rr_dispatch.sv
// Bench for demux_rr_dispatch (DATA_W=8, NUM_OUT=4, MAX_WAIT=3): per-cycle vector
// table, hand-written corner sequences and an in-order data scoreboard.
module tb_demux_rr_dispatch;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic [7:0] skip_cnt;

  int n_vec;
  int n_err;

  logic [7:0] exp_q[$];
  logic [7:0] log_data[$];
  logic [1:0] log_lane[$];

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic [3:0] ordy;
    logic       e_ir;
    logic [3:0] e_ov;
    logic [1:0] e_sel;
    logic [7:0] e_data;
    logic [7:0] e_skip;
  } vec_t;

  vec_t tbl[8];

  demux_rr_dispatch #(
    .DATA_W   (8),
    .NUM_OUT  (4),
    .MAX_WAIT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .skip_cnt  (skip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge; return at the falling edge.
  task automatic cyc(input logic iv, input logic [7:0] id, input logic [3:0] ordy);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
  endtask

  // Scoreboard: accepted words are queued, every dispatch must pop the oldest one.
  always @(negedge clk) begin
    if (!rst) begin
      if ((out_valid & out_ready) != 4'b0000) begin
        log_data.push_back(out_data);
        log_lane.push_back(out_sel);
        $display("dispatch lane %0d data 0x%02h", out_sel, out_data);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_dispatch", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
      end
    end
  end

  initial begin
    bit seen[4];
    int  exp_skip;

    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 4'b0000;

    //             iv  data   ordy     ir    ov       sel    data   skip
    tbl[0] = '{1'b1, 8'h11, 4'b1101, 1'b1, 4'b0000, 2'd0, 8'h00, 8'd0};
    tbl[1] = '{1'b1, 8'h22, 4'b1101, 1'b1, 4'b0001, 2'd0, 8'h11, 8'd0};
    tbl[2] = '{1'b0, 8'h00, 4'b1101, 1'b0, 4'b0010, 2'd1, 8'h22, 8'd0};
    tbl[3] = '{1'b0, 8'h00, 4'b1101, 1'b0, 4'b0010, 2'd1, 8'h22, 8'd0};
    tbl[4] = '{1'b0, 8'h00, 4'b1101, 1'b0, 4'b0010, 2'd1, 8'h22, 8'd0};
    tbl[5] = '{1'b0, 8'h00, 4'b1101, 1'b0, 4'b0010, 2'd1, 8'h22, 8'd0};
    tbl[6] = '{1'b0, 8'h00, 4'b1101, 1'b1, 4'b0100, 2'd2, 8'h22, 8'd1};
    tbl[7] = '{1'b0, 8'h00, 4'b1101, 1'b1, 4'b0000, 2'd3, 8'h22, 8'd1};

    // Power-on reset values
    @(negedge clk);
    chk("rst_out_valid", {28'd0, out_valid}, 32'h0);
    chk("rst_out_sel",   {30'd0, out_sel},   32'h0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'h1);
    chk("rst_skip_cnt",  {24'd0, skip_cnt},  32'h0);
    chk("rst_out_data",  {24'd0, out_data},  32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Lane 1 stalls: 0x11 on lane 0, 0x22 offered 4 cycles on lane 1, skipped, lands on lane 2
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].iv, tbl[i].id, tbl[i].ordy);
      chk($sformatf("tbl%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].e_ir});
      chk($sformatf("tbl%0d_out_valid", i), {28'd0, out_valid}, {28'd0, tbl[i].e_ov});
      chk($sformatf("tbl%0d_out_sel", i),   {30'd0, out_sel},   {30'd0, tbl[i].e_sel});
      chk($sformatf("tbl%0d_out_data", i),  {24'd0, out_data},  {24'd0, tbl[i].e_data});
      chk($sformatf("tbl%0d_skip_cnt", i),  {24'd0, skip_cnt},  {24'd0, tbl[i].e_skip});
    end

    // Asynchronous reset while a word is held
    cyc(1'b1, 8'h77, 4'b0000);
    cyc(1'b0, 8'h00, 4'b0000);
    chk("pre_rst_hold_valid", {28'd0, out_valid}, 32'h8);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {28'd0, out_valid}, 32'h0);
    chk("midrst_out_sel",   {30'd0, out_sel},   32'h0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'h1);
    chk("midrst_skip_cnt",  {24'd0, skip_cnt},  32'h0);
    chk("midrst_out_data",  {24'd0, out_data},  32'h0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back stream with all lanes ready
    log_data.delete();
    log_lane.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'hA0 + 8'(i), 4'b1111);
      chk($sformatf("stream%0d_in_ready", i), {31'd0, in_ready}, 32'h1);
    end
    cyc(1'b0, 8'h00, 4'b1111);
    cyc(1'b0, 8'h00, 4'b1111);
    chk("stream_dispatch_count", log_data.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_data.size()) begin
        chk($sformatf("stream%0d_lane", i), {30'd0, log_lane[i]}, i % 4);
        chk($sformatf("stream%0d_data", i), {24'd0, log_data[i]}, 32'hA0 + i);
      end
    end

    // Ready arrives on the would-be skip cycle: dispatch wins
    cyc(1'b1, 8'h33, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 8'h00, 4'b0000);
      chk($sformatf("late_rdy_stall%0d_valid", k), {28'd0, out_valid}, 32'h1);
    end
    cyc(1'b0, 8'h00, 4'b0001);
    chk("late_rdy_valid",    {28'd0, out_valid}, 32'h1);
    chk("late_rdy_in_ready", {31'd0, in_ready},  32'h1);
    cyc(1'b0, 8'h00, 4'b0000);
    chk("late_rdy_skip_cnt", {24'd0, skip_cnt},  32'h0);
    chk("late_rdy_out_sel",  {30'd0, out_sel},   32'h1);
    chk("late_rdy_empty",    {28'd0, out_valid}, 32'h0);
    chk("late_rdy_log_data", {24'd0, log_data[log_data.size()-1]}, 32'h33);
    chk("late_rdy_log_lane", {30'd0, log_lane[log_lane.size()-1]}, 32'h0);

    // New word accepted in the same cycle as a dispatch: no bubble
    cyc(1'b1, 8'h44, 4'b1111);
    cyc(1'b1, 8'h55, 4'b1111);
    chk("nobub_in_ready",  {31'd0, in_ready},  32'h1);
    chk("nobub_valid0",    {28'd0, out_valid}, 32'h2);
    chk("nobub_data0",     {24'd0, out_data},  32'h44);
    cyc(1'b0, 8'h00, 4'b1111);
    chk("nobub_valid1",    {28'd0, out_valid}, 32'h4);
    chk("nobub_data1",     {24'd0, out_data},  32'h55);

    // Long stall: word rotates through all lanes and the skip counter saturates
    cyc(1'b1, 8'h66, 4'b0000);
    for (int k = 0; k < 2000; k++) begin
      cyc(1'b0, 8'h00, 4'b0000);
      exp_skip = (k / 4 > 255) ? 255 : k / 4;
      seen[out_sel] = 1'b1;
      chk($sformatf("stall%0d_in_ready", k), {31'd0, in_ready}, 32'h0);
      chk($sformatf("stall%0d_out_sel", k),  {30'd0, out_sel},  (3 + k / 4) % 4);
      chk($sformatf("stall%0d_skip_cnt", k), {24'd0, skip_cnt}, exp_skip);
    end
    chk("stall_all_lanes_seen", {28'd0, seen[3], seen[2], seen[1], seen[0]}, 32'hF);
    chk("stall_skip_sat", {24'd0, skip_cnt}, 32'd255);
    cyc(1'b0, 8'h00, 4'b1111);
    chk("release_data", {24'd0, out_data}, 32'h66);
    cyc(1'b0, 8'h00, 4'b0000);
    chk("release_log_lane", {30'd0, log_lane[log_lane.size()-1]}, 32'h3);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_demux_rr_dispatch
